// File: rtl/vector_ctrl_pkg.sv
// Shared types for the vector control sequencer: op classes, FSM states, extend selects.
// Pure declarations; no timing or flow control of its own.
package vector_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CTRL    = 2'b00,
    OP_ALU_RR  = 2'b01,
    OP_ALU_IMM = 2'b10,
    OP_MEM     = 2'b11
  } opClass_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEXEC = 2'b01,
    VALU  = 2'b10,
    VMEM  = 2'b11
  } state_t;

  localparam logic [1:0] EXT_NONE  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_HIGH  = 2'b10;
  localparam logic [1:0] EXT_SHIFT = 2'b11;

  localparam logic [1:0] MEM_LOAD  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;

  function automatic int beatWidth(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vector_ctrl_seq_if.sv
// Instruction, memory handshake and decoded-strobe bundle of the vector sequencer.
// master drives instructions and acks; slave is the sequencer.
interface vector_ctrl_seq_if #(
  parameter int LANES = 4,
  parameter int BW    = 2
) ();
  logic             instr_valid;
  logic [1:0]       op;
  logic [1:0]       inst;
  logic             VF;
  logic             flush;
  logic             mem_ack;
  logic             instr_ready;
  logic             busy;
  logic             done;
  logic             wreg_en;
  logic             rmem_en;
  logic             wmem_en;
  logic             cond_en;
  logic             jmp_en;
  logic [2:0]       alu_op;
  logic [1:0]       ext_sel;
  logic [LANES-1:0] vlane_en;
  logic [BW-1:0]    beat_idx;
  logic             mem_req;
  logic             mem_we;

  modport master (
    output instr_valid, op, inst, VF, flush, mem_ack,
    input  instr_ready, busy, done, wreg_en, rmem_en, wmem_en, cond_en, jmp_en,
    input  alu_op, ext_sel, vlane_en, beat_idx, mem_req, mem_we
  );

  modport slave (
    input  instr_valid, op, inst, VF, flush, mem_ack,
    output instr_ready, busy, done, wreg_en, rmem_en, wmem_en, cond_en, jmp_en,
    output alu_op, ext_sel, vlane_en, beat_idx, mem_req, mem_we
  );
endinterface

// File: rtl/vector_ctrl_decode.sv
// Combinational op/inst decode into control strobes, ALU function and extend select.
// Zero latency; no flow control.
module vector_ctrl_decode
  import vector_ctrl_pkg::*;
(
  input  opClass_t   op,
  input  logic [1:0] inst,
  output logic       wregEn,
  output logic       rmemEn,
  output logic       wmemEn,
  output logic       condEn,
  output logic       jmpEn,
  output logic [2:0] aluOp,
  output logic [1:0] extSel
);

  always_comb begin
    wregEn = 1'b0;
    rmemEn = 1'b0;
    wmemEn = 1'b0;
    condEn = 1'b0;
    jmpEn  = 1'b0;
    extSel = EXT_NONE;
    aluOp  = {op[0], inst};
    case (op)
      OP_CTRL: begin
        jmpEn  = inst[0];
        condEn = inst[1];
      end
      OP_ALU_RR:  wregEn = 1'b1;
      OP_ALU_IMM: begin
        wregEn = 1'b1;
        extSel = inst;
      end
      OP_MEM: begin
        case (inst)
          MEM_LOAD: begin
            rmemEn = 1'b1;
            wregEn = 1'b1;
          end
          MEM_STORE: wmemEn = 1'b1;
          default:   condEn = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vector_ctrl_seq.sv
// Sequences one instruction at a time: 1 cycle scalar, BEATS cycles vector ALU, ack-paced vector memory.
// instr_ready only in IDLE; memory beats stall until mem_ack; flush aborts to IDLE next cycle.
module vector_ctrl_seq
  import vector_ctrl_pkg::*;
#(
  parameter int VLEN  = 16,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  vector_ctrl_seq_if.slave bus
);

  localparam int BEATS = VLEN / LANES;
  localparam int BW    = beatWidth(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t        state;
  opClass_t      opQ;
  logic [1:0]    instQ;
  logic          vfQ;
  logic [BW-1:0] beatQ;

  logic       decWreg, decRmem, decWmem, decCond, decJmp;
  logic [2:0] decAlu;
  logic [1:0] decExt;
  logic       active, memXfer, isStore, isLoad, lastBeat, advance, memReq;

  vector_ctrl_decode uDecode (
    .op     (opQ),
    .inst   (instQ),
    .wregEn (decWreg),
    .rmemEn (decRmem),
    .wmemEn (decWmem),
    .condEn (decCond),
    .jmpEn  (decJmp),
    .aluOp  (decAlu),
    .extSel (decExt)
  );

  // Vector compares live in VMEM but never touch memory; they step one beat per cycle.
  assign active   = (state != IDLE);
  assign memXfer  = vfQ && (opQ == OP_MEM) && !instQ[1];
  assign isLoad   = memXfer && (instQ == MEM_LOAD);
  assign isStore  = memXfer && (instQ == MEM_STORE);
  assign lastBeat = (beatQ == LAST_BEAT);
  assign advance  = (state == VALU) || ((state == VMEM) && (!memXfer || bus.mem_ack));
  assign memReq   = (state == VMEM) && memXfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      opQ   <= OP_CTRL;
      instQ <= 2'b00;
      vfQ   <= 1'b0;
      beatQ <= '0;
    end else if (state == IDLE) begin
      beatQ <= '0;
      if (bus.instr_valid) begin
        opQ   <= opClass_t'(bus.op);
        instQ <= bus.inst;
        vfQ   <= bus.VF;
        if (!bus.VF || (bus.op == OP_CTRL)) state <= SEXEC;
        else if (bus.op == OP_MEM)          state <= VMEM;
        else                                state <= VALU;
      end
    end else if (bus.flush || (state == SEXEC)) begin
      state <= IDLE;
      beatQ <= '0;
    end else if (advance) begin
      if (lastBeat) begin
        state <= IDLE;
        beatQ <= '0;
      end else begin
        beatQ <= beatQ + BW'(1);
      end
    end
  end

  assign bus.instr_ready = !active;
  assign bus.busy        = active;
  assign bus.done        = !bus.flush && ((state == SEXEC) || (advance && lastBeat));
  assign bus.wreg_en     = active && decWreg;
  assign bus.rmem_en     = active && decRmem;
  assign bus.wmem_en     = active && decWmem;
  assign bus.cond_en     = active && decCond;
  assign bus.jmp_en      = active && decJmp;
  assign bus.alu_op      = active ? decAlu : 3'b000;
  assign bus.ext_sel     = active ? decExt : EXT_NONE;
  assign bus.vlane_en    = ((state == VALU) || ((state == VMEM) && isLoad && bus.mem_ack))
                           ? {LANES{1'b1}} : {LANES{1'b0}};
  assign bus.beat_idx    = beatQ;
  assign bus.mem_req     = memReq;
  assign bus.mem_we      = memReq && isStore;

endmodule

// File: tb/tb_vector_ctrl_seq.sv
// Randomized and directed bench for vector_ctrl_seq against a per-instruction trace model.
module tb_vector_ctrl_seq;

  localparam int VLEN  = 16;
  localparam int LANES = 4;
  localparam int BEATS = VLEN / LANES;
  localparam int BW    = 2;

  typedef struct packed {
    logic             ready, busy, done, wreg, rmem, wmem, cond, jmp;
    logic [2:0]       alu;
    logic [1:0]       ext;
    logic [LANES-1:0] vlane;
    logic [BW-1:0]    beat;
    logic             req, we;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_ctrl_seq_if #(.LANES(LANES), .BW(BW)) bus ();
  vector_ctrl_seq #(.VLEN(VLEN), .LANES(LANES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   nChecks = 0;
  int   nFail   = 0;
  vec_t expQ[$];
  bit   ackQ[$];
  bit   flushQ[$];
  int   dly[BEATS];
  logic [1:0] curOp, curInst;
  logic       curVf;

  function automatic vec_t sample();
    vec_t v;
    v.ready = bus.instr_ready; v.busy = bus.busy; v.done = bus.done;
    v.wreg = bus.wreg_en; v.rmem = bus.rmem_en; v.wmem = bus.wmem_en;
    v.cond = bus.cond_en; v.jmp = bus.jmp_en; v.alu = bus.alu_op; v.ext = bus.ext_sel;
    v.vlane = bus.vlane_en; v.beat = bus.beat_idx; v.req = bus.mem_req; v.we = bus.mem_we;
    return v;
  endfunction

  // Expected cycle-by-cycle trace of one instruction: accept cycle, execution, trailing idle cycle.
  function automatic void model(input logic [1:0] op, input logic [1:0] inst, input logic vf,
                                input int flushAt);
    vec_t idle, e;
    logic [4:0] str;
    bit ack;
    curOp = op; curInst = inst; curVf = vf;
    expQ.delete(); ackQ.delete(); flushQ.delete();
    idle = '0;
    idle.ready = 1'b1;
    expQ.push_back(idle); ackQ.push_back(1'($urandom)); flushQ.push_back($urandom_range(0, 3) == 0);
    case (op)
      2'd0:       str = {3'b000, inst[1], inst[0]};
      2'd1, 2'd2: str = 5'b10000;
      default:    str = (inst == 2'd0) ? 5'b11000 : (inst == 2'd1) ? 5'b00100 : 5'b00010;
    endcase
    e = '0;
    e.busy = 1'b1;
    {e.wreg, e.rmem, e.wmem, e.cond, e.jmp} = str;
    e.alu = {op[0], inst};
    e.ext = (op == 2'd2) ? inst : 2'b00;
    if (!vf || op == 2'd0) begin
      e.done = 1'b1;
      expQ.push_back(e); ackQ.push_back(1'($urandom)); flushQ.push_back(1'b0);
    end else if (op != 2'd3 || inst[1]) begin
      for (int b = 0; b < BEATS; b++) begin
        e.beat  = BW'(b);
        e.vlane = (op != 2'd3) ? '1 : '0;
        e.done  = (b == BEATS - 1);
        expQ.push_back(e); ackQ.push_back(1'($urandom)); flushQ.push_back(1'b0);
      end
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        for (int w = 0; w <= dly[b]; w++) begin
          ack     = (w == dly[b]);
          e.beat  = BW'(b);
          e.req   = 1'b1;
          e.we    = (inst == 2'd1);
          e.vlane = (inst == 2'd0 && ack) ? '1 : '0;
          e.done  = ack && (b == BEATS - 1);
          expQ.push_back(e); ackQ.push_back(ack); flushQ.push_back(1'b0);
        end
      end
    end
    if (flushAt > 0 && flushAt < expQ.size()) begin
      while (expQ.size() > flushAt + 1) begin
        void'(expQ.pop_back()); void'(ackQ.pop_back()); void'(flushQ.pop_back());
      end
      expQ[flushAt].done = 1'b0;
      flushQ[flushAt] = 1'b1;
    end
    expQ.push_back(idle); ackQ.push_back(1'($urandom)); flushQ.push_back($urandom_range(0, 3) == 0);
  endfunction

  // Drive cycle i of the current trace; non-accept cycles carry random noise on the instruction inputs.
  task automatic play(input int i);
    @(posedge clk);
    #1;
    if (i == 0) begin
      bus.instr_valid = 1'b1; bus.op = curOp; bus.inst = curInst; bus.VF = curVf;
    end else begin
      bus.instr_valid = (i == expQ.size() - 1) ? 1'b0 : 1'($urandom);
      bus.op = 2'($urandom); bus.inst = 2'($urandom); bus.VF = 1'($urandom);
    end
    bus.flush   = flushQ[i];
    bus.mem_ack = ackQ[i];
    @(negedge clk);
  endtask

  task automatic test_reset();
    vec_t got;
    bus.instr_valid = 1'b0; bus.op = 2'd0; bus.inst = 2'd0; bus.VF = 1'b0;
    bus.flush = 1'b0; bus.mem_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = sample();
    nChecks++;
    if (got !== vec_t'(21'h100000)) begin
      nFail++; $display("FAIL reset_hold: got %h want %h", got, vec_t'(21'h100000));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    got = sample();
    nChecks++;
    if (got !== vec_t'(21'h100000)) begin
      nFail++; $display("FAIL reset_release: got %h want %h", got, vec_t'(21'h100000));
    end
  endtask

  task automatic test_scalar();
    vec_t got;
    model(2'd1, 2'd2, 1'b0, 0);
    for (int i = 0; i < expQ.size(); i++) begin
      play(i);
      got = sample();
      nChecks++;
      if (got !== expQ[i]) begin
        nFail++; $display("FAIL scalar cycle %0d: got %h want %h", i, got, expQ[i]);
      end
      if (i == 1) begin
        nChecks++;
        if (got.alu !== 3'b110 || got.wreg !== 1'b1 || got.done !== 1'b1) begin
          nFail++; $display("FAIL scalar_alu: got alu=%b wreg=%b done=%b want 110 1 1",
                            got.alu, got.wreg, got.done);
        end
      end
    end
  endtask

  task automatic test_valu();
    vec_t got;
    model(2'd2, 2'($urandom), 1'b1, 0);
    for (int i = 0; i < expQ.size(); i++) begin
      play(i);
      got = sample();
      nChecks++;
      if (got !== expQ[i]) begin
        nFail++; $display("FAIL valu cycle %0d: got %h want %h", i, got, expQ[i]);
      end
    end
  endtask

  task automatic test_vload();
    vec_t got;
    int reqCycles = 0;
    int doneCycles = 0;
    for (int b = 0; b < BEATS; b++) dly[b] = 2;
    model(2'd3, 2'd0, 1'b1, 0);
    for (int i = 0; i < expQ.size(); i++) begin
      play(i);
      got = sample();
      reqCycles += int'(got.req);
      doneCycles += int'(got.done);
      nChecks++;
      if (got !== expQ[i]) begin
        nFail++; $display("FAIL vload cycle %0d: got %h want %h", i, got, expQ[i]);
      end
    end
    nChecks++;
    if (reqCycles != 12 || doneCycles != 1) begin
      nFail++; $display("FAIL vload_len: got req=%0d done=%0d want 12 1", reqCycles, doneCycles);
    end
  endtask

  task automatic test_flush_store();
    vec_t got;
    dly = '{1, 1, 2, 2};
    model(2'd3, 2'd1, 1'b1, 5);
    for (int i = 0; i < expQ.size(); i++) begin
      play(i);
      got = sample();
      nChecks++;
      if (got !== expQ[i]) begin
        nFail++; $display("FAIL flush_store cycle %0d: got %h want %h", i, got, expQ[i]);
      end
    end
  endtask

  task automatic test_flush_idle();
    vec_t got;
    model(2'd0, 2'd3, 1'b1, 0);
    flushQ[0] = 1'b1;
    for (int i = 0; i < expQ.size(); i++) begin
      play(i);
      got = sample();
      nChecks++;
      if (got !== expQ[i]) begin
        nFail++; $display("FAIL flush_idle cycle %0d: got %h want %h", i, got, expQ[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t got;
    dly = '{0, 3, 0, 0};
    model(2'd3, 2'd0, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      play(i);
      got = sample();
      nChecks++;
      if (got !== expQ[i]) begin
        nFail++; $display("FAIL reset_mid_pre cycle %0d: got %h want %h", i, got, expQ[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0; bus.instr_valid = 1'b0; bus.mem_ack = 1'b0; bus.flush = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    got = sample();
    nChecks++;
    if (got !== vec_t'(21'h100000)) begin
      nFail++; $display("FAIL reset_mid: got %h want %h", got, vec_t'(21'h100000));
    end
    model(2'd1, 2'd3, 1'b0, 0);
    for (int i = 0; i < expQ.size(); i++) begin
      play(i);
      got = sample();
      nChecks++;
      if (got !== expQ[i]) begin
        nFail++; $display("FAIL reset_mid_next cycle %0d: got %h want %h", i, got, expQ[i]);
      end
    end
  endtask

  task automatic test_random();
    vec_t got;
    int flushAt;
    for (int n = 0; n < 60; n++) begin
      for (int b = 0; b < BEATS; b++) dly[b] = $urandom_range(0, 3);
      flushAt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      model(2'($urandom), 2'($urandom), 1'($urandom), flushAt);
      for (int i = 0; i < expQ.size(); i++) begin
        play(i);
        got = sample();
        nChecks++;
        if (got !== expQ[i]) begin
          nFail++;
          $display("FAIL random n=%0d op=%0d inst=%0d vf=%0d cycle %0d: got %h want %h",
                   n, curOp, curInst, curVf, i, got, expQ[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_valu();
    test_vload();
    test_flush_store();
    test_flush_idle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/vector_ctrl_seq.md
VECTOR_CTRL_SEQ -- requirements
Module: vector_ctrl_seq

Interface
REQ-001 Parameter VLEN, default 16: vector length in pixel elements; SHALL be a power of two, at least 2.
REQ-002 Parameter LANES, default 4: elements processed per beat; SHALL be a power of two dividing VLEN; BEATS = VLEN/LANES, BW = max(1, clog2(BEATS)).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 instr_valid  in  1  op/inst/VF present.
REQ-006 op, inst  in  2 each  instruction class and subtype.
REQ-007 VF  in  1  1 = vector instruction.
REQ-008 flush  in  1  abort the current instruction.
REQ-009 mem_ack  in  1  memory completed the current beat.
REQ-010 instr_ready  out  1  accept strobe; high only in IDLE.
REQ-011 busy, done  out  1 each  instruction in flight; one-cycle completion pulse.
REQ-012 wreg_en, rmem_en, wmem_en, cond_en, jmp_en  out  1 each  decoded strobes.
REQ-013 alu_op  out  3  ALU function; ext_sel  out  2  immediate extend select.
REQ-014 vlane_en  out  LANES  per-lane write enable.
REQ-015 beat_idx  out  BW  current beat, 0..BEATS-1.
REQ-016 mem_req, mem_we  out  1 each  vector memory request and direction.

Function
REQ-017 Decode: op=00 control (jmp_en=inst[0], cond_en=inst[1]); op=01 ALU reg-reg (wreg_en); op=10 ALU immediate (wreg_en, ext_sel=inst); op=11 memory (inst=00 load: rmem_en, wreg_en; inst=01 store: wmem_en; inst=1x compare: cond_en).
REQ-018 alu_op SHALL equal {op[0], inst}; ext_sel SHALL be 00 unless op=10.
REQ-019 op, inst and VF SHALL be latched on the cycle where instr_valid and instr_ready are both high; outputs SHALL be driven from the latched copy only.
REQ-020 States: IDLE, SEXEC, VALU, VMEM.
REQ-021 IDLE -> SEXEC if VF=0; IDLE -> VALU if VF=1 and op!=11; IDLE -> VMEM if VF=1 and op=11.
REQ-022 VF=1 with op=00 SHALL be treated as a scalar control op (-> SEXEC).
REQ-023 SEXEC: decoded strobes SHALL be high for exactly one cycle, together with done; next state IDLE.
REQ-024 VALU: run BEATS consecutive cycles with beat_idx 0..BEATS-1; vlane_en all ones and wreg_en high each beat.
REQ-025 VALU: done SHALL be high on the last beat; next state IDLE.
REQ-026 VMEM: mem_req held high and beat_idx held until mem_ack; mem_we = latched store; rmem_en/wmem_en follow mem_req.
REQ-027 VMEM: vlane_en all ones only in an ack cycle of a load.
REQ-028 VMEM: beat_idx SHALL advance on mem_ack; done and return to IDLE on the ack of beat BEATS-1.
REQ-029 VMEM: vector compare (inst=1x) SHALL run as VALU timing with cond_en instead of wreg_en.
REQ-030 Scalar memory ops (VF=0, op=11) SHALL take SEXEC and SHALL NOT assert mem_req.
REQ-031 flush in any non-IDLE state: next cycle IDLE, all strobes low, beat_idx 0, no done pulse.
REQ-032 flush in IDLE: no effect; same-cycle instr_valid is still accepted.
REQ-033 flush has priority over mem_ack and beat advance.
REQ-034 Outside the active states, all strobes, vlane_en and mem_req SHALL be 0.
REQ-035 busy = (state != IDLE).

Reset
REQ-036 rst_n low at a clock edge: state IDLE, beat_idx 0, latched instruction 0, all outputs 0 except instr_ready=1; applies mid-instruction, and no done pulse is issued.

Structure
REQ-037 Package vector_ctrl_pkg SHALL hold the op-class enum, the state enum and the ext_sel encodings.
REQ-038 Combinational decode SHALL be one sub-module, vector_ctrl_decode (op, inst -> strobes, alu_op, ext_sel); the FSM and beat counter stay in vector_ctrl_seq.

Verification
REQ-039 Scalar: op=01, inst=10, VF=0 accepted at cycle N -> wreg_en, done, alu_op=110 high at N+1 only; instr_ready at N+2.
REQ-040 Vector ALU (VLEN=16, LANES=4): op=10, VF=1 -> 4 cycles, beat_idx 0,1,2,3, vlane_en=1111, done on the fourth.
REQ-041 Vector load, mem_ack delayed 2 cycles per beat -> mem_req high 12 cycles, beat_idx held between acks, done on the 4th ack.
REQ-042 flush during beat 2 of a vector store -> IDLE next cycle, mem_req low, beat_idx 0, no done.
REQ-043 rst_n low during VMEM beat 1 -> all outputs 0 and instr_ready=1 after the edge; the next instruction decodes normally.
